// File: rtl/hamming_byte_assembler.sv
// hamming_byte_assembler
// Pairs decoded Hamming nibbles (low nibble first) into bytes, queues them in
// a small FIFO behind a valid/ready interface, and keeps saturating counts of
// corrected and uncorrectable nibbles.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   nibble handshake; in_nibble data, in_err decoder flag
//   resync              drop any held low nibble, restart pairing
//   clear_counts        zero both error counters (wins over an increment)
//   out_valid/out_ready byte handshake; out_byte {hi,lo}, out_uncorr flag
//   level               FIFO occupancy
//   corr_count          accepted nibbles with in_err=01
//   uncorr_count        accepted nibbles with in_err=1x
module hamming_byte_assembler #(
  parameter int DEPTH = 4,
  parameter int CW    = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_nibble,
  input  logic [1:0]    in_err,
  input  logic          resync,
  input  logic          clear_counts,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_byte,
  output logic          out_uncorr,
  output logic [LW-1:0] level,
  output logic [CW-1:0] corr_count,
  output logic [CW-1:0] uncorr_count
);

  typedef enum logic [0:0] {LO = 1'b0, HI = 1'b1} state_t;

  state_t          state_r, state_s;
  logic [3:0]      hold_nibble_r, hold_nibble_s;
  logic            hold_uncorr_r, hold_uncorr_s;
  logic            ready_r, ready_s;
  logic [8:0]      mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r, wr_ptr_s;
  logic [AW-1:0]   rd_ptr_r, rd_ptr_s;
  logic [LW-1:0]   level_r, level_s;
  logic            out_valid_r, out_valid_s;
  logic [8:0]      head_r, head_s;
  logic [CW-1:0]   corr_r, corr_s;
  logic [CW-1:0]   uncorr_r, uncorr_s;
  logic            accept_s;
  logic            push_s;
  logic            pop_s;
  logic [8:0]      push_data_s;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == {CW{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CW-1){1'b0}}, 1'b1};
    end
  endfunction

  // in_ready is registered except for the resync gate, so it never follows
  // out_ready combinationally.
  assign in_ready     = ready_r & ~resync;
  assign out_valid    = out_valid_r;
  assign out_byte     = head_r[7:0];
  assign out_uncorr   = head_r[8];
  assign level        = level_r;
  assign corr_count   = corr_r;
  assign uncorr_count = uncorr_r;

  // Handshake decode and pairing state machine next-state.
  always_comb begin
    accept_s      = in_valid & in_ready;
    push_s        = accept_s & (state_r == HI);
    pop_s         = out_valid_r & out_ready;
    push_data_s   = {hold_uncorr_r | in_err[1], in_nibble, hold_nibble_r};
    state_s       = state_r;
    hold_nibble_s = hold_nibble_r;
    hold_uncorr_s = hold_uncorr_r;
    if (resync) begin
      state_s       = LO;
      hold_nibble_s = 4'h0;
      hold_uncorr_s = 1'b0;
    end else if (accept_s) begin
      case (state_r)
        LO: begin
          state_s       = HI;
          hold_nibble_s = in_nibble;
          hold_uncorr_s = in_err[1];
        end
        HI: begin
          state_s = LO;
        end
        default: begin
          state_s = LO;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // FIFO pointers, occupancy and the next head entry presented on the outputs.
  always_comb begin
    wr_ptr_s    = wr_ptr_r + {{(AW-1){1'b0}}, push_s};
    rd_ptr_s    = rd_ptr_r + {{(AW-1){1'b0}}, pop_s};
    level_s     = level_r + {{(LW-1){1'b0}}, push_s} - {{(LW-1){1'b0}}, pop_s};
    out_valid_s = (level_s != {LW{1'b0}});
    if (level_s == {LW{1'b0}}) begin
      head_s = 9'h000;
    end else if (push_s && ((level_r - {{(LW-1){1'b0}}, pop_s}) == {LW{1'b0}})) begin
      // FIFO drains to empty this edge, so the byte being pushed becomes head.
      head_s = push_data_s;
    end else begin
      head_s = mem_r[rd_ptr_s];
    end
    if (state_s == LO) begin
      ready_s = 1'b1;
    end else begin
      ready_s = (level_s != LW'(DEPTH));
    end
  end

  // Error counters: clear wins over increment, increments saturate.
  always_comb begin
    corr_s   = corr_r;
    uncorr_s = uncorr_r;
    if (clear_counts) begin
      corr_s   = {CW{1'b0}};
      uncorr_s = {CW{1'b0}};
    end else if (accept_s) begin
      if (in_err == 2'b01) begin
        corr_s = sat_inc(corr_r);
      end else begin
        corr_s = corr_r;
      end
      if (in_err[1]) begin
        uncorr_s = sat_inc(uncorr_r);
      end else begin
        uncorr_s = uncorr_r;
      end
    end else begin
      corr_s   = corr_r;
      uncorr_s = uncorr_r;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= LO;
      hold_nibble_r <= 4'h0;
      hold_uncorr_r <= 1'b0;
      ready_r       <= 1'b1;
      wr_ptr_r      <= {AW{1'b0}};
      rd_ptr_r      <= {AW{1'b0}};
      level_r       <= {LW{1'b0}};
      out_valid_r   <= 1'b0;
      head_r        <= 9'h000;
      corr_r        <= {CW{1'b0}};
      uncorr_r      <= {CW{1'b0}};
    end else begin
      state_r       <= state_s;
      hold_nibble_r <= hold_nibble_s;
      hold_uncorr_r <= hold_uncorr_s;
      ready_r       <= ready_s;
      wr_ptr_r      <= wr_ptr_s;
      rd_ptr_r      <= rd_ptr_s;
      level_r       <= level_s;
      out_valid_r   <= out_valid_s;
      head_r        <= head_s;
      corr_r        <= corr_s;
      uncorr_r      <= uncorr_s;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_data_s;
    end
  end

endmodule

// File: tb/tb_hamming_byte_assembler.sv
// Directed self-checking bench for hamming_byte_assembler (DEPTH=4, CW=4).
module tb_hamming_byte_assembler;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_nibble;
  logic [1:0] in_err;
  logic       resync;
  logic       clear_counts;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic       out_uncorr;
  logic [2:0] level;
  logic [3:0] corr_count;
  logic [3:0] uncorr_count;

  int n_assert = 0;
  int n_fail   = 0;

  hamming_byte_assembler #(.DEPTH(4), .CW(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_nibble(in_nibble), .in_err(in_err),
    .resync(resync), .clear_counts(clear_counts),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte), .out_uncorr(out_uncorr),
    .level(level), .corr_count(corr_count), .uncorr_count(uncorr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] n, input logic [1:0] e);
    in_valid  = v;
    in_nibble = n;
    in_err    = e;
  endtask

  logic [7:0] exp_bytes [4];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; resync = 1'b0; clear_counts = 1'b0; out_ready = 1'b0;
    drive(1'b0, 4'h0, 2'b00);
    tick(); tick();
    rst = 1'b0;
    chk("rst_level", level, 3'd0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_byte", out_byte, 8'h00);
    chk("rst_out_uncorr", out_uncorr, 1'b0);
    chk("rst_corr", corr_count, 4'd0);
    chk("rst_uncorr", uncorr_count, 4'd0);
    chk("rst_in_ready", in_ready, 1'b1);

    // Clean pair 0x5, 0xA -> 0xA5
    out_ready = 1'b1;
    drive(1'b1, 4'h5, 2'b00); tick();
    chk("lo_no_output", out_valid, 1'b0);
    drive(1'b1, 4'hA, 2'b00); tick();
    drive(1'b0, 4'h0, 2'b00);
    chk("a5_valid", out_valid, 1'b1);
    chk("a5_byte", out_byte, 8'hA5);
    chk("a5_uncorr", out_uncorr, 1'b0);
    chk("a5_level", level, 3'd1);
    chk("a5_corr", corr_count, 4'd0);
    chk("a5_uncorr_cnt", uncorr_count, 4'd0);
    tick();
    chk("a5_popped", level, 3'd0);
    chk("a5_popped_byte", out_byte, 8'h00);

    // Corrected + uncorrectable pair
    drive(1'b1, 4'h3, 2'b01); tick();
    drive(1'b1, 4'hC, 2'b10); tick();
    drive(1'b0, 4'h0, 2'b00);
    chk("c3_byte", out_byte, 8'hC3);
    chk("c3_uncorr", out_uncorr, 1'b1);
    chk("c3_corr", corr_count, 4'd1);
    chk("c3_uncorr_cnt", uncorr_count, 4'd1);
    tick();
    drive(1'b1, 4'h9, 2'b11); tick();
    drive(1'b0, 4'h0, 2'b00);
    chk("err11_uncorr_cnt", uncorr_count, 4'd2);
    resync = 1'b1; tick(); resync = 1'b0;
    chk("resync_keeps_counts", uncorr_count, 4'd2);

    // Backpressure: stream 10 nibbles with out_ready low
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 4'(i), 2'b00); tick();
    end
    drive(1'b1, 4'h9, 2'b00); #1;
    chk("full_in_ready", in_ready, 1'b0);
    chk("full_level", level, 3'd4);
    chk("full_head", out_byte, 8'h10);
    tick();
    chk("stall_head_stable", out_byte, 8'h10);
    chk("stall_in_ready", in_ready, 1'b0);
    out_ready = 1'b1; #1;
    chk("ready_not_comb", in_ready, 1'b0);
    tick();
    out_ready = 1'b0;
    chk("pop_release_ready", in_ready, 1'b1);
    chk("pop_level", level, 3'd3);
    tick();
    drive(1'b0, 4'h0, 2'b00);
    chk("refill_level", level, 3'd4);
    exp_bytes[0] = 8'h32; exp_bytes[1] = 8'h54; exp_bytes[2] = 8'h76; exp_bytes[3] = 8'h98;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_valid_%0d", i), out_valid, 1'b1);
      chk($sformatf("drain_byte_%0d", i), out_byte, exp_bytes[i]);
      tick();
    end
    chk("drained_level", level, 3'd0);
    chk("drained_valid", out_valid, 1'b0);
    chk("drained_byte", out_byte, 8'h00);

    // Resync discards held low nibble
    drive(1'b1, 4'h7, 2'b00); tick();
    resync = 1'b1;
    drive(1'b1, 4'h1, 2'b00); #1;
    chk("resync_in_ready", in_ready, 1'b0);
    tick();
    resync = 1'b0;
    tick();
    drive(1'b1, 4'h2, 2'b00); tick();
    drive(1'b0, 4'h0, 2'b00);
    chk("resync_byte", out_byte, 8'h21);
    chk("resync_uncorr", out_uncorr, 1'b0);
    tick();

    // Saturation of corr_count (starts at 1)
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 4'h0, 2'b01); tick();
    end
    chk("corr_sat", corr_count, 4'd15);
    drive(1'b1, 4'h0, 2'b01); tick();
    chk("corr_sat_hold", corr_count, 4'd15);
    clear_counts = 1'b1;
    drive(1'b1, 4'h0, 2'b01); tick();
    clear_counts = 1'b0;
    drive(1'b0, 4'h0, 2'b00);
    chk("clear_prio_corr", corr_count, 4'd0);
    chk("clear_uncorr", uncorr_count, 4'd0);
    tick();

    // Reset with one byte queued and a low nibble held
    out_ready = 1'b0;
    drive(1'b1, 4'h4, 2'b01); tick();
    drive(1'b1, 4'h6, 2'b01); tick();
    drive(1'b0, 4'h0, 2'b00);
    chk("pre_rst_level", level, 3'd1);
    chk("pre_rst_corr", corr_count, 4'd2);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst2_level", level, 3'd0);
    chk("rst2_valid", out_valid, 1'b0);
    chk("rst2_byte", out_byte, 8'h00);
    chk("rst2_corr", corr_count, 4'd0);
    chk("rst2_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    drive(1'b1, 4'h0, 2'b00); tick();
    drive(1'b1, 4'hF, 2'b00); tick();
    drive(1'b0, 4'h0, 2'b00);
    chk("post_rst_byte", out_byte, 8'hF0);
    chk("post_rst_valid", out_valid, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
